mc_bus_bridge: RTL and testbench
================================

# mc_bus_bridge

Parametrised successor to the MCU parallel-bus register interface. It synchronises the MCU's asynchronous active-low strobes (`mc_ce`, `mc_we`, `mc_oe`) into the FPGA clock domain, decodes `mc_add`, and routes each access to one of three places: a TX/RX FIFO data port, a status word, or a parametrised register file. It sits between the top-level `mc_data` tristate pad and the protocol engines; the top level builds the tristate from `mc_data_out`/`mc_data_oe`.

## Interface
- `MC_DATA_WIDTH`, 16: bus and FIFO word width; must be ≥16.
- `MC_ADD_WIDTH`, 6: address width.
- `FIFO_DEPTH`, 16: depth of each FIFO; power of 2, 2..128.
- `NUM_REGS`, 62: register count, mapped at addresses 2..NUM_REGS+1; must satisfy NUM_REGS ≤ 2^MC_ADD_WIDTH−2.

- `clock` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `mc_ce` in 1: chip enable, active-low, asynchronous.
- `mc_we` in 1: write strobe, active-low, asynchronous.
- `mc_oe` in 1: read strobe, active-low, asynchronous.
- `mc_add` in MC_ADD_WIDTH: bus address.
- `mc_data_in` in MC_DATA_WIDTH: write data from the pad.
- `mc_data_out` out MC_DATA_WIDTH: read data to the pad.
- `mc_data_oe` out 1: pad drive enable, active-high.
- `tx_data` out MC_DATA_WIDTH, `tx_valid` out 1, `tx_ready` in 1: TX FIFO head (valid/ready).
- `rx_data` in MC_DATA_WIDTH, `rx_valid` in 1, `rx_ready` out 1: RX FIFO tail (valid/ready).
- `reg_q` out NUM_REGS*MC_DATA_WIDTH: flat register file; register i occupies bits [i*W +: W].
- `reg_wr` out 1: one-cycle pulse on each register write.
- `reg_wr_index` out 8: index of the register written.
- `irq_rx` out 1: RX FIFO not empty.
- `irq_tx` out 1: TX FIFO empty.

## Operation
- Synchronisation: `mc_ce`, `mc_we`, `mc_oe` each pass through a 2-flop synchroniser that resets to 1. `mc_add` and `mc_data_in` are registered once per clock into `add_q`/`din_q`.
- Bus contract: address and data are stable from 1 clock before the strobe falls until 3 clocks after it rises. Strobes stay low for ≥4 clocks.
- Address map:
  - 0: write pushes TX FIFO; read returns RX head, and the pop happens at end of read.
  - 1: status, read-only. Bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 rx_underflow (sticky), bit4 tx_overflow (sticky), bits[15:8] rx_count (zero-extended). All other bits read 0.
  - 2..NUM_REGS+1: register index = addr−2.
  - Any other address: writes ignored, reads return 0.
- FSM states:
  - IDLE: waits for a strobe.
  - WRITE: holds until `we_s` high.
  - READ: holds until `oe_s` high or `ce_s` high.
  - ARM: entered after reset; stays until `we_s` and `oe_s` are both high, then goes to IDLE.
- IDLE with `ce_s`=0 and falling `we_s`: commit the write using `add_q`/`din_q` in that same cycle, then go to WRITE.
- IDLE with `ce_s`=0 and falling `oe_s` (and no write edge): latch `mc_data_out` from the addressed source, assert `mc_data_oe`, then go to READ.
- Write and read edges in the same cycle: the write wins and the read is ignored.
- READ exit: deassert `mc_data_oe`. If the address was 0 and RX was not empty, pop RX. If the address was 1, clear both sticky bits (a flag set in that same cycle stays set).
- Write to address 0 with TX full: word dropped, tx_overflow set. The full check uses the count before any same-cycle pop.
- Read of address 0 with RX empty: returns 0, sets rx_underflow, no pop.
- RX: `rx_ready` = not full. Push and pop in the same cycle both succeed and the count is unchanged.
- TX: `tx_valid` = not empty; `tx_data` is the FIFO head. Pop occurs on `tx_valid && tx_ready`.
- Register writes: update `reg_q` and pulse `reg_wr` with `reg_wr_index` in the commit cycle.
- Pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - 0: `mc_data_out`, `mc_data_oe`, `reg_q`, `reg_wr`, `reg_wr_index`, `tx_valid`, `irq_rx`, both FIFOs, both sticky flags.
  - 1: `rx_ready`, `irq_tx`.
  - FSM state: ARM.
- Write commit: in the 3rd clock edge after `mc_we` falls (2 synchroniser flops plus edge detect).
- Read: `mc_data_out`/`mc_data_oe` valid from the 3rd clock edge after `mc_oe` falls. `mc_data_oe` drops and the RX pop occurs at the 3rd edge after `mc_oe` rises.
- `irq_rx`/`irq_tx` are registered and lag the FIFO count by 1 clock.
- Reset asserted mid-access: all state clears at that edge. A strobe still low when reset releases is ignored (ARM) until it returns high.

## Test plan
- Write addr 0x19 with data 0x0003 → `reg_wr` pulses once, `reg_wr_index`=23, `reg_q[23]`=0x0003. Then write addr 0x1A with 0x0003 → `reg_q[24]`=0x0003 and `reg_q[23]` is unchanged.
- With `tx_ready`=0, write 0x0055, 0x0020, 0x0202, 0x0303 to addr 0 → `irq_tx`=0. Then raise `tx_ready` → `tx_data` drains 0x0055, 0x0020, 0x0202, 0x0303 on consecutive clocks, then `tx_valid`=0 and `irq_tx`=1.
- Push RX 0xA5A5 and 0x1234, then read addr 0 twice → first read `mc_data_out`=0xA5A5 from the 3rd clock after `mc_oe` falls, second read =0x1234. Status bits[15:8] go 2 → 1 → 0. A third read returns 0x0000 and sets bit3.
- Perform 17 writes to addr 0 with FIFO_DEPTH=16 and `tx_ready`=0 → 17th word dropped. Status reads 0x0012, then 0x0002 on the next read (sticky cleared).
- Assert `reset` while `mc_oe` is low on addr 1 → `mc_data_oe`=0 at the next edge. No read occurs until `mc_oe` goes high and then low again.
- Drop `mc_we` and `mc_oe` in the same clock on a register address → write commits and `mc_data_oe` stays 0.

Source files
------------

// File: rtl/mc_bus_bridge_if.sv
// MCU parallel-bus signal bundle.
// master: MCU side, drives strobes, address and write data, observes read data.
// slave : bridge side, consumes strobes/address/data, drives read data and pad enable.
// Strobes mc_ce/mc_we/mc_oe are active-low and asynchronous to the bridge clock.
interface mc_bus_bridge_if #(
    parameter int unsigned MC_DATA_WIDTH = 16,
    parameter int unsigned MC_ADD_WIDTH  = 6
);
    logic                     mc_ce;
    logic                     mc_we;
    logic                     mc_oe;
    logic [MC_ADD_WIDTH-1:0]  mc_add;
    logic [MC_DATA_WIDTH-1:0] mc_data_in;
    logic [MC_DATA_WIDTH-1:0] mc_data_out;
    logic                     mc_data_oe;

    modport master (
        output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
        input  mc_data_out, mc_data_oe
    );

    modport slave (
        input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
        output mc_data_out, mc_data_oe
    );
endinterface

// File: rtl/mc_bus_bridge.sv
// MCU parallel-bus bridge: synchronises the MCU strobes, decodes the address and
// routes accesses to a TX/RX FIFO data port (addr 0), a status word (addr 1) or a
// register file (addr 2..NUM_REGS+1).
// Ports:
//   clock, reset      : single clock domain, synchronous active-high reset
//   bus (slave)       : MCU strobes/address/data in, read data + pad enable out
//   tx_data/valid/ready : TX FIFO head, valid/ready
//   rx_data/valid/ready : RX FIFO tail, valid/ready
//   reg_q             : flat register file, register i at [i*W +: W]
//   reg_wr, reg_wr_index : one-cycle pulse and index on each register write
//   irq_rx, irq_tx    : registered RX-not-empty / TX-empty
// Assumes MC_DATA_WIDTH >= 16, FIFO_DEPTH a power of 2 in 2..128,
// NUM_REGS <= 2**MC_ADD_WIDTH - 2.
module mc_bus_bridge #(
    parameter int unsigned MC_DATA_WIDTH = 16,
    parameter int unsigned MC_ADD_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned NUM_REGS      = 62
) (
    input  logic                              clock,
    input  logic                              reset,
    mc_bus_bridge_if.slave                    bus,
    output logic [MC_DATA_WIDTH-1:0]          tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    input  logic [MC_DATA_WIDTH-1:0]          rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic [NUM_REGS*MC_DATA_WIDTH-1:0] reg_q,
    output logic                              reg_wr,
    output logic [7:0]                        reg_wr_index,
    output logic                              irq_rx,
    output logic                              irq_tx
);

    localparam int unsigned W     = MC_DATA_WIDTH;
    localparam int unsigned AW    = MC_ADD_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_ARM,
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

    state_t state;

    // synchronisers, edge-detect history and input registers
    logic [1:0]    ce_sync, we_sync, oe_sync;
    logic          ce_s, we_s, oe_s;
    logic          we_d, oe_d;
    logic [1:0]    sync_fill;
    logic [AW-1:0] add_q;
    logic [W-1:0]  din_q;

    // FIFO state
    logic [W-1:0]     tx_mem [FIFO_DEPTH];
    logic [W-1:0]     rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             rx_underflow, tx_overflow;

    // register file and read bookkeeping
    logic [W-1:0] regs [NUM_REGS];
    logic         rd_pop_q, rd_status_q;

    // decoded events
    logic             we_fall, oe_fall;
    logic             wr_commit, rd_start, rd_exit;
    logic             tx_full, rx_empty;
    logic             tx_push, tx_pop, tx_ovf_set;
    logic             rx_push, rx_pop, rx_unf_set, sticky_clr;
    logic [AW-1:0]    reg_off;
    logic             reg_hit;
    logic [IDX_W-1:0] reg_idx;
    logic [W-1:0]     status, rd_mux;

    assign ce_s = ce_sync[1];
    assign we_s = we_sync[1];
    assign oe_s = oe_sync[1];

    // FIFO-facing handshakes follow the FIFO state directly (no extra cycle)
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign rx_ready = (rx_count != CNT_W'(FIFO_DEPTH));

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*W +: W] = regs[g];
    end

    // Event decode: strobe edges, FIFO pushes/pops, sticky flag set/clear
    always_comb begin
        we_fall    = we_d & ~we_s;
        oe_fall    = oe_d & ~oe_s;
        wr_commit  = (state == S_IDLE) && !ce_s && we_fall;
        rd_start   = (state == S_IDLE) && !ce_s && oe_fall && !we_fall;
        rd_exit    = (state == S_READ) && (oe_s || ce_s);

        tx_full    = (tx_count == CNT_W'(FIFO_DEPTH));
        rx_empty   = (rx_count == '0);

        // full check uses the pre-pop count, so a same-cycle drain does not save the word
        tx_push    = wr_commit && (add_q == '0) && !tx_full;
        tx_ovf_set = wr_commit && (add_q == '0) && tx_full;
        tx_pop     = tx_valid && tx_ready;

        rx_push    = rx_valid && rx_ready;
        rx_pop     = rd_exit && rd_pop_q;
        rx_unf_set = rd_start && (add_q == '0) && rx_empty;
        sticky_clr = rd_exit && rd_status_q;

        reg_off    = add_q - AW'(2);
        reg_hit    = (add_q >= AW'(2)) && (32'(reg_off) < NUM_REGS);
        reg_idx    = IDX_W'(reg_off);
    end

    // Status word and read-data source select
    always_comb begin
        status        = '0;
        status[0]     = !rx_empty;
        status[1]     = tx_full;
        status[2]     = (tx_count == '0);
        status[3]     = rx_underflow;
        status[4]     = tx_overflow;
        status[15:8]  = 8'(rx_count);

        rd_mux = '0;
        if (add_q == '0) begin
            if (!rx_empty) rd_mux = rx_mem[rx_rd_ptr];
        end else if (add_q == AW'(1)) begin
            rd_mux = status;
        end else if (reg_hit) begin
            rd_mux = regs[reg_idx];
        end
    end

    // Strobe synchronisers and once-per-clock address/data capture
    always_ff @(posedge clock) begin
        if (reset) begin
            ce_sync   <= 2'b11;
            we_sync   <= 2'b11;
            oe_sync   <= 2'b11;
            we_d      <= 1'b1;
            oe_d      <= 1'b1;
            sync_fill <= 2'd0;
            add_q     <= '0;
            din_q     <= '0;
        end else begin
            ce_sync   <= {ce_sync[0], bus.mc_ce};
            we_sync   <= {we_sync[0], bus.mc_we};
            oe_sync   <= {oe_sync[0], bus.mc_oe};
            we_d      <= we_s;
            oe_d      <= oe_s;
            // counts edges until the synchroniser outputs reflect real pad samples
            if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
            add_q     <= bus.mc_add;
            din_q     <= bus.mc_data_in;
        end
    end

    // Access FSM with registered pad outputs and register-file writes
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_ARM;
            bus.mc_data_out <= '0;
            bus.mc_data_oe  <= 1'b0;
            rd_pop_q        <= 1'b0;
            rd_status_q     <= 1'b0;
            reg_wr          <= 1'b0;
            reg_wr_index    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr <= 1'b0;
            case (state)
                // reset-time strobes are reset values, not samples; wait for real highs
                S_ARM: begin
                    if (sync_fill == 2'd2 && we_s && oe_s) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (wr_commit) begin
                        state <= S_WRITE;
                    end else if (rd_start) begin
                        state           <= S_READ;
                        bus.mc_data_out <= rd_mux;
                        bus.mc_data_oe  <= 1'b1;
                        rd_pop_q        <= (add_q == '0) && !rx_empty;
                        rd_status_q     <= (add_q == AW'(1));
                    end
                end
                S_WRITE: begin
                    if (we_s) state <= S_IDLE;
                end
                S_READ: begin
                    if (rd_exit) begin
                        state          <= S_IDLE;
                        bus.mc_data_oe <= 1'b0;
                        rd_pop_q       <= 1'b0;
                        rd_status_q    <= 1'b0;
                    end
                end
                default: state <= S_ARM;
            endcase

            if (wr_commit && reg_hit) begin
                regs[reg_idx] <= din_q;
                reg_wr        <= 1'b1;
                reg_wr_index  <= 8'(reg_off);
            end
        end
    end

    // FIFO storage (no reset needed: contents are qualified by the counts)
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= din_q;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    // FIFO pointers, counts, sticky flags and interrupts
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
            irq_rx       <= 1'b0;
            irq_tx       <= 1'b1;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);

            // a set in the clearing cycle wins
            rx_underflow <= (rx_underflow & ~sticky_clr) | rx_unf_set;
            tx_overflow  <= (tx_overflow & ~sticky_clr) | tx_ovf_set;

            irq_rx <= (rx_count != '0);
            irq_tx <= (tx_count == '0);
        end
    end

endmodule

// File: tb/tb_mc_bus_bridge.sv
module tb_mc_bus_bridge;
    localparam int W     = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 16;
    localparam int NREG  = 62;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [W-1:0]      tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [W-1:0]      rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [NREG*W-1:0] reg_q;
    logic              reg_wr;
    logic [7:0]        reg_wr_index;
    logic              irq_rx;
    logic              irq_tx;

    mc_bus_bridge_if #(.MC_DATA_WIDTH(W), .MC_ADD_WIDTH(AW)) bus ();

    mc_bus_bridge #(
        .MC_DATA_WIDTH(W),
        .MC_ADD_WIDTH (AW),
        .FIFO_DEPTH   (DEPTH),
        .NUM_REGS     (NREG)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .reg_q       (reg_q),
        .reg_wr      (reg_wr),
        .reg_wr_index(reg_wr_index),
        .irq_rx      (irq_rx),
        .irq_tx      (irq_tx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // register-write pulse monitor, sampled just after each rising edge
    int         wr_pulses = 0;
    logic [7:0] last_idx  = 8'd0;
    always @(posedge clock) begin
        #1;
        if (reg_wr === 1'b1) begin
            wr_pulses++;
            last_idx = reg_wr_index;
        end
    end

    // behavioural model of the bridge as seen from the bus
    logic [W-1:0] m_regs [NREG];
    logic [W-1:0] m_txq [$];
    logic [W-1:0] m_rxq [$];
    bit           m_unf;
    bit           m_ovf;

    function automatic logic [W-1:0] reg_at(input int i);
        logic [NREG*W-1:0] v;
        v = reg_q;
        return v[i*W +: W];
    endfunction

    function automatic logic [W-1:0] model_status();
        logic [W-1:0] s;
        s = '0;
        s[0]    = (m_rxq.size() != 0);
        s[1]    = (m_txq.size() == DEPTH);
        s[2]    = (m_txq.size() == 0);
        s[3]    = m_unf;
        s[4]    = m_ovf;
        s[15:8] = 8'(m_rxq.size());
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_txq.delete();
        m_rxq.delete();
        m_unf = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_write(input int a, input logic [W-1:0] d);
        if (a == 0) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(d);
            else m_ovf = 1'b1;
        end else if (a >= 2 && a < NREG + 2) begin
            m_regs[a-2] = d;
        end
    endtask

    task automatic model_read(input int a, output logic [W-1:0] v);
        v = '0;
        if (a == 0) begin
            if (m_rxq.size() == 0) m_unf = 1'b1;
            else v = m_rxq.pop_front();
        end else if (a == 1) begin
            v = model_status();
            m_unf = 1'b0;
            m_ovf = 1'b0;
        end else if (a < NREG + 2) begin
            v = m_regs[a-2];
        end
    endtask

    // MCU write cycle: address/data one clock ahead, strobe low 5 clocks, hold 4 after
    task automatic bus_write(input int a, input logic [W-1:0] d);
        @(negedge clock);
        bus.mc_add     = AW'(a);
        bus.mc_data_in = d;
        bus.mc_ce      = 1'b0;
        @(negedge clock);
        bus.mc_we = 1'b0;
        repeat (5) @(negedge clock);
        bus.mc_we = 1'b1;
        repeat (4) @(negedge clock);
        bus.mc_ce = 1'b1;
    endtask

    // MCU read cycle with latency checks on the pad enable and data
    task automatic bus_read(input int a, input logic [W-1:0] exp, input string tag);
        @(negedge clock);
        bus.mc_add = AW'(a);
        bus.mc_ce  = 1'b0;
        @(negedge clock);
        bus.mc_oe = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rd_early_oe: got %b want 0", tag, bus.mc_data_oe);
        end
        @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rd_oe: got %b want 1", tag, bus.mc_data_oe);
        end
        n_checks++;
        if (bus.mc_data_out !== exp) begin
            n_fail++;
            $display("FAIL %s rd_data: got %h want %h", tag, bus.mc_data_out, exp);
        end
        repeat (2) @(negedge clock);
        bus.mc_oe = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rd_hold_oe: got %b want 1", tag, bus.mc_data_oe);
        end
        @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rd_release_oe: got %b want 0", tag, bus.mc_data_oe);
        end
        bus.mc_ce = 1'b1;
    endtask

    task automatic push_rx(input logic [W-1:0] d, input string tag);
        logic want_ready;
        @(negedge clock);
        want_ready = (m_rxq.size() < DEPTH);
        n_checks++;
        if (rx_ready !== want_ready) begin
            n_fail++;
            $display("FAIL %s rx_ready: got %b want %b", tag, rx_ready, want_ready);
        end
        rx_data  = d;
        rx_valid = 1'b1;
        if (want_ready) m_rxq.push_back(d);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.mc_data_oe !== 1'b0 || bus.mc_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_pad: got oe=%b out=%h want oe=0 out=0000", bus.mc_data_oe, bus.mc_data_out);
        end
        n_checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fifo: got tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
        end
        n_checks++;
        if (irq_rx !== 1'b0 || irq_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_irq: got irq_rx=%b irq_tx=%b want 0/1", irq_rx, irq_tx);
        end
        n_checks++;
        if (reg_wr !== 1'b0 || reg_wr_index !== 8'd0 || reg_q !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got reg_wr=%b idx=%0d reg_q_nonzero=%b want 0/0/0",
                     reg_wr, reg_wr_index, (reg_q != '0));
        end
        repeat (4) @(negedge clock);
        bus_read(1, model_status(), "reset_status");
    endtask

    task automatic test_regs();
        int p0;
        p0 = wr_pulses;
        model_write(8'h19, 16'h0003);
        bus_write(8'h19, 16'h0003);
        n_checks++;
        if (wr_pulses - p0 !== 1 || last_idx !== 8'd23) begin
            n_fail++;
            $display("FAIL regs_pulse: got pulses=%0d idx=%0d want 1/23", wr_pulses - p0, last_idx);
        end
        n_checks++;
        if (reg_at(23) !== 16'h0003) begin
            n_fail++;
            $display("FAIL regs_q23: got %h want 0003", reg_at(23));
        end
        model_write(8'h1A, 16'h0003);
        bus_write(8'h1A, 16'h0003);
        n_checks++;
        if (reg_at(24) !== 16'h0003 || reg_at(23) !== 16'h0003) begin
            n_fail++;
            $display("FAIL regs_q24: got q24=%h q23=%h want 0003/0003", reg_at(24), reg_at(23));
        end
        model_write(63, 16'hC0DE);
        bus_write(63, 16'hC0DE);
        n_checks++;
        if (reg_at(61) !== 16'hC0DE || last_idx !== 8'd61) begin
            n_fail++;
            $display("FAIL regs_top: got q61=%h idx=%0d want c0de/61", reg_at(61), last_idx);
        end
        bus_read(8'h19, m_regs[23], "regs_rd23");
        bus_write(1, 16'hFFFF);
        bus_read(1, model_status(), "regs_status_ro");
    endtask

    task automatic test_tx_drain();
        logic [W-1:0] words [4];
        logic [W-1:0] exp;
        words[0] = 16'h0055; words[1] = 16'h0020; words[2] = 16'h0202; words[3] = 16'h0303;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_write(0, words[i]);
            bus_write(0, words[i]);
        end
        @(negedge clock);
        n_checks++;
        if (irq_tx !== 1'b0 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_loaded: got irq_tx=%b tx_valid=%b want 0/1", irq_tx, tx_valid);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = m_txq.pop_front();
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_fail++;
                $display("FAIL tx_drain%0d: got valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp);
            end
            @(negedge clock);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_empty_valid: got %b want 0", tx_valid);
        end
        @(negedge clock);
        n_checks++;
        if (irq_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_empty_irq: got %b want 1", irq_tx);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_read();
        logic [W-1:0] v;
        push_rx(16'hA5A5, "rx_push0");
        push_rx(16'h1234, "rx_push1");
        repeat (2) @(negedge clock);
        n_checks++;
        if (irq_rx !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_irq: got %b want 1", irq_rx);
        end
        bus_read(1, 16'h0205, "rx_status2");
        model_read(1, v);
        model_read(0, v);
        bus_read(0, v, "rx_read0");
        bus_read(1, 16'h0105, "rx_status1");
        model_read(1, v);
        model_read(0, v);
        bus_read(0, v, "rx_read1");
        bus_read(1, 16'h0004, "rx_status0");
        model_read(1, v);
        model_read(0, v);
        bus_read(0, v, "rx_read_empty");
        bus_read(1, 16'h000C, "rx_status_unf");
        model_read(1, v);
        bus_read(1, 16'h0004, "rx_status_cleared");
        model_read(1, v);
    endtask

    task automatic test_rx_full();
        logic [W-1:0] v;
        for (int i = 0; i < DEPTH + 1; i++) push_rx(16'(16'h3000 + i), "rxf_push");
        model_read(1, v);
        bus_read(1, v, "rxf_status");
        for (int i = 0; i < DEPTH; i++) begin
            model_read(0, v);
            bus_read(0, v, "rxf_read");
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (irq_rx !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rxf_drained: got irq_rx=%b rx_ready=%b want 0/1", irq_rx, rx_ready);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            model_write(0, 16'(16'h0100 + i));
            bus_write(0, 16'(16'h0100 + i));
        end
        bus_read(1, 16'h0012, "ovf_status");
        model_read(1, v);
        bus_read(1, 16'h0002, "ovf_cleared");
        model_read(1, v);
        @(negedge clock);
        n_checks++;
        if (tx_data !== 16'h0100) begin
            n_fail++;
            $display("FAIL ovf_head: got %h want 0100", tx_data);
        end
        tx_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge clock);
        tx_ready = 1'b0;
        m_txq.delete();
        n_checks++;
        if (tx_valid !== 1'b0 || irq_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drained: got tx_valid=%b irq_tx=%b want 0/1", tx_valid, irq_tx);
        end
    endtask

    task automatic test_simultaneous();
        int  p0;
        bit  saw_oe;
        p0 = wr_pulses;
        saw_oe = 1'b0;
        @(negedge clock);
        bus.mc_add     = AW'(5);
        bus.mc_data_in = 16'hBEEF;
        bus.mc_ce      = 1'b0;
        @(negedge clock);
        bus.mc_we = 1'b0;
        bus.mc_oe = 1'b0;
        model_write(5, 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.mc_data_oe !== 1'b0) saw_oe = 1'b1;
        end
        bus.mc_we = 1'b1;
        bus.mc_oe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.mc_data_oe !== 1'b0) saw_oe = 1'b1;
        end
        bus.mc_ce = 1'b1;
        n_checks++;
        if (saw_oe) begin
            n_fail++;
            $display("FAIL simul_oe: got mc_data_oe asserted want 0");
        end
        n_checks++;
        if (wr_pulses - p0 !== 1 || reg_at(3) !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL simul_write: got pulses=%0d q3=%h want 1/beef", wr_pulses - p0, reg_at(3));
        end
    endtask

    task automatic test_reset_mid();
        bit saw_oe;
        saw_oe = 1'b0;
        @(negedge clock);
        bus.mc_add = AW'(1);
        bus.mc_ce  = 1'b0;
        @(negedge clock);
        bus.mc_oe = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_oe: got %b want 1", bus.mc_data_oe);
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.mc_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_oe: got %b want 0", bus.mc_data_oe);
        end
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (reg_q !== '0 || irq_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: got reg_q_nonzero=%b irq_tx=%b want 0/1", (reg_q != '0), irq_tx);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.mc_data_oe !== 1'b0) saw_oe = 1'b1;
        end
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.mc_data_oe !== 1'b0) saw_oe = 1'b1;
        end
        n_checks++;
        if (saw_oe) begin
            n_fail++;
            $display("FAIL rstmid_armed: got mc_data_oe asserted while strobe held want 0");
        end
        bus_read(1, model_status(), "rstmid_reread");
    endtask

    task automatic test_random();
        int           op, a, r;
        logic [W-1:0] d, v;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 5);
            a  = (r < 2) ? r : $urandom_range(0, 63);
            d  = 16'($urandom);
            if (op == 0) begin
                model_write(a, d);
                bus_write(a, d);
            end else if (op == 1) begin
                model_read(a, v);
                bus_read(a, v, "rand_read");
            end else begin
                push_rx(d, "rand_push");
            end
        end
        for (int i = 0; i < NREG; i++) begin
            n_checks++;
            if (reg_at(i) !== m_regs[i]) begin
                n_fail++;
                $display("FAIL rand_reg%0d: got %h want %h", i, reg_at(i), m_regs[i]);
            end
        end
        @(negedge clock);
        n_checks++;
        if (tx_valid !== (m_txq.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_tx_valid: got %b want %b", tx_valid, (m_txq.size() != 0));
        end
        if (m_txq.size() != 0) begin
            n_checks++;
            if (tx_data !== m_txq[0]) begin
                n_fail++;
                $display("FAIL rand_tx_head: got %h want %h", tx_data, m_txq[0]);
            end
        end
        bus_read(1, model_status(), "rand_status");
    endtask

    initial begin
        reset          = 1'b1;
        bus.mc_ce      = 1'b1;
        bus.mc_we      = 1'b1;
        bus.mc_oe      = 1'b1;
        bus.mc_add     = '0;
        bus.mc_data_in = '0;
        tx_ready       = 1'b0;
        rx_data        = '0;
        rx_valid       = 1'b0;
        model_reset();
        repeat (4) @(negedge clock);
        reset = 1'b0;

        test_reset();
        test_regs();
        test_tx_drain();
        test_rx_read();
        test_rx_full();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
